core_run_checker: RTL and testbench

- Synthesizable, parametrised successor to the milestone quick-test flow: preloads data memory from a vector table, holds the core in reset, releases it, and waits for `done` under a timeout.
- After `done` it compares selected data-memory words against expected values and reports pass/fail, error count and first failing address.
- Sits in top_level beside the core; its dm port is muxed onto the data memory whenever `busy` is high.

---
 rtl/core_run_checker_if.sv | 25 ++
 rtl/core_run_checker.sv | 151 +++++++++++++++
 tb/tb_core_run_checker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_checker_if.sv
// Data-memory and vector-table bus between the run checker (master) and the
// memory/table side (slave).
interface core_run_checker_if #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int VIW = 3
);
  logic [VIW-1:0] vec_idx;
  logic [AW-1:0]  vec_addr;
  logic [DW-1:0]  vec_data;
  logic           dm_we;
  logic [AW-1:0]  dm_addr;
  logic [DW-1:0]  dm_wdata;
  logic [DW-1:0]  dm_rdata;

  modport master (
    output vec_idx, dm_we, dm_addr, dm_wdata,
    input  vec_addr, vec_data, dm_rdata
  );

  modport slave (
    input  vec_idx, dm_we, dm_addr, dm_wdata,
    output vec_addr, vec_data, dm_rdata
  );
endinterface

// File: rtl/core_run_checker.sv
// Preloads data memory, runs the core under a timeout, then compares result words.
// States: IDLE wait start | LOAD preload | HOLD core reset | RUN core live | CHECK compare | DONE results held
module core_run_checker #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int N_INIT  = 4,
  parameter int N_CHECK = 2,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 1024,
  parameter int CCW     = 16,
  parameter int VIW     = (N_INIT + N_CHECK > 0) ? $clog2(N_INIT + N_CHECK + 1) : 1,
  parameter int ECW     = (N_CHECK > 0) ? $clog2(N_CHECK + 1) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  core_run_checker_if.master  bus,
  output logic                core_reset,
  input  logic                core_done,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic                timed_out,
  output logic [ECW-1:0]      err_count,
  output logic [AW-1:0]       first_err_addr,
  output logic [CCW-1:0]      cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_CHECK, S_DONE} state_e;

  localparam int              HCW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [HCW-1:0]  HOLD_INIT  = HCW'(RST_CYC - 1);
  localparam logic [VIW-1:0]  LAST_LOAD  = VIW'((N_INIT > 0) ? N_INIT - 1 : 0);
  localparam logic [VIW-1:0]  LAST_CHECK = VIW'((N_CHECK > 0) ? N_INIT + N_CHECK - 1 : 0);
  localparam logic [31:0]     TO_LIM     = 32'(TIMEOUT);

  state_e          state_q, state_d;
  logic [VIW-1:0]  vec_idx_q, vec_idx_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CCW-1:0]  cycle_count_q, cycle_count_d, cyc_inc;
  logic [ECW-1:0]  err_count_q, err_count_d;
  logic [AW-1:0]   first_err_addr_q, first_err_addr_d;
  logic            pass_q, pass_d, fail_q, fail_d, timed_out_q, timed_out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      vec_idx_q        <= '0;
      hold_cnt_q       <= HOLD_INIT;
      cycle_count_q    <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      pass_q           <= 1'b0;
      fail_q           <= 1'b0;
      timed_out_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_idx_q        <= vec_idx_d;
      hold_cnt_q       <= hold_cnt_d;
      cycle_count_q    <= cycle_count_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      pass_q           <= pass_d;
      fail_q           <= fail_d;
      timed_out_q      <= timed_out_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    vec_idx_d        = vec_idx_q;
    hold_cnt_d       = HOLD_INIT;
    cycle_count_d    = cycle_count_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    pass_d           = pass_q;
    fail_d           = fail_q;
    timed_out_d      = timed_out_q;
    core_reset       = 1'b1;
    busy             = 1'b0;
    bus.dm_we        = 1'b0;
    bus.dm_addr      = '0;
    bus.dm_wdata     = '0;
    cyc_inc          = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_idx_d        = '0;
          cycle_count_d    = '0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          pass_d           = 1'b0;
          fail_d           = 1'b0;
          timed_out_d      = 1'b0;
          state_d          = (N_INIT > 0) ? S_LOAD : S_HOLD;
        end
      end
      S_LOAD: begin
        busy         = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = bus.vec_addr;
        bus.dm_wdata = bus.vec_data;
        vec_idx_d    = vec_idx_q + 1'b1;
        if (vec_idx_q == LAST_LOAD) state_d = S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (hold_cnt_q == '0) state_d = S_RUN;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      S_RUN: begin
        busy          = 1'b1;
        core_reset    = 1'b0;
        cycle_count_d = cyc_inc;
        // done on the terminal cycle still counts as a successful finish
        if (core_done) begin
          state_d = (N_CHECK > 0) ? S_CHECK : S_DONE;
        end else if (TO_LIM != 32'd0 && 32'(cyc_inc) >= TO_LIM) begin
          timed_out_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_CHECK: begin
        busy        = 1'b1;
        bus.dm_addr = bus.vec_addr;
        vec_idx_d   = vec_idx_q + 1'b1;
        if (bus.dm_rdata != bus.vec_data) begin
          err_count_d = err_count_q + 1'b1;
          if (err_count_q == '0) first_err_addr_d = bus.vec_addr;
        end
        if (vec_idx_q == LAST_CHECK) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      pass_d = (err_count_d == '0) && !timed_out_d;
      fail_d = !pass_d;
    end
  end

  assign bus.vec_idx    = vec_idx_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timed_out      = timed_out_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_core_run_checker.sv
// Directed bench: three checker instances (default, short timeout, empty tables)
// each with its own memory and a simple core model.
module tb_core_run_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic [2:0]  core_reset, core_done;
  logic [2:0]  busy, pass, fail, timed_out;
  logic [1:0]  err_count      [3];
  logic [7:0]  first_err_addr [3];
  logic [15:0] cycle_count    [3];

  int          done_at  [3];
  logic [7:0]  core_val [3];
  logic [7:0]  tab_addr [3][8];
  logic [7:0]  tab_data [3][8];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_run_checker_if #(.DW(8), .AW(8), .VIW(3)) bus [3] ();

  core_run_checker #(.N_INIT(4), .N_CHECK(2), .TIMEOUT(1024)) u_a (
    .clk(clk), .reset(reset), .start(start[0]), .bus(bus[0]),
    .core_reset(core_reset[0]), .core_done(core_done[0]),
    .busy(busy[0]), .pass(pass[0]), .fail(fail[0]), .timed_out(timed_out[0]),
    .err_count(err_count[0]), .first_err_addr(first_err_addr[0]), .cycle_count(cycle_count[0])
  );

  core_run_checker #(.N_INIT(4), .N_CHECK(2), .TIMEOUT(16)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .bus(bus[1]),
    .core_reset(core_reset[1]), .core_done(core_done[1]),
    .busy(busy[1]), .pass(pass[1]), .fail(fail[1]), .timed_out(timed_out[1]),
    .err_count(err_count[1]), .first_err_addr(first_err_addr[1]), .cycle_count(cycle_count[1])
  );

  core_run_checker #(.N_INIT(0), .N_CHECK(0), .VIW(3), .ECW(2)) u_c (
    .clk(clk), .reset(reset), .start(start[2]), .bus(bus[2]),
    .core_reset(core_reset[2]), .core_done(core_done[2]),
    .busy(busy[2]), .pass(pass[2]), .fail(fail[2]), .timed_out(timed_out[2]),
    .err_count(err_count[2]), .first_err_addr(first_err_addr[2]), .cycle_count(cycle_count[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_m
    logic [7:0] mem [256];
    int         run_cnt;

    assign bus[g].vec_addr = tab_addr[g][bus[g].vec_idx];
    assign bus[g].vec_data = tab_data[g][bus[g].vec_idx];
    assign bus[g].dm_rdata = mem[bus[g].dm_addr];
    assign core_done[g]    = !core_reset[g] && done_at[g] != 0 && run_cnt == done_at[g] - 1;

    always @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j < 256; j++) mem[j] <= 8'h00;
        mem[5] <= 8'h41;
      end else begin
        if (bus[g].dm_we) mem[bus[g].dm_addr] <= bus[g].dm_wdata;
        if (!core_reset[g] && run_cnt == 0) mem[0] <= core_val[g];
      end
      run_cnt <= core_reset[g] ? 0 : run_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = '0;
    done_at  = '{0, 0, 0};
    core_val = '{8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 2; i++) begin
      tab_addr[i] = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h00, 8'h05, 8'h00, 8'h00};
      tab_data[i] = '{8'h01, 8'h02, 8'hC3, 8'h55, 8'h03, 8'h41, 8'h00, 8'h00};
    end
    tab_addr[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tab_data[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) tick();

    chk("rst_core_reset", core_reset[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_fail", fail[0], 0);
    chk("rst_timed_out", timed_out[0], 0);
    chk("rst_err_count", err_count[0], 0);
    chk("rst_first_err", first_err_addr[0], 0);
    chk("rst_cycle_count", cycle_count[0], 0);
    chk("rst_dm_we", bus[0].dm_we, 0);
    chk("rst_dm_addr", bus[0].dm_addr, 0);
    chk("rst_dm_wdata", bus[0].dm_wdata, 0);
    chk("rst_vec_idx", bus[0].vec_idx, 0);
    reset = 1'b0;
    tick();

    // Run 1: core writes 03, done after 20 RUN cycles; both checks match
    done_at[0] = 20; core_val[0] = 8'h03;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("r1_k1_core_reset", core_reset[0], 1);
    chk("r1_k1_busy", busy[0], 1);
    chk("r1_k1_dm_we", bus[0].dm_we, 1);
    chk("r1_k1_dm_addr", bus[0].dm_addr, 8'h00);
    chk("r1_k1_dm_wdata", bus[0].dm_wdata, 8'h01);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("r1_k2_dm_addr", bus[0].dm_addr, 8'h01);
    chk("r1_k2_dm_wdata", bus[0].dm_wdata, 8'h02);
    tick();
    chk("r1_k3_dm_addr", bus[0].dm_addr, 8'h03);
    chk("r1_k3_dm_wdata", bus[0].dm_wdata, 8'hC3);
    tick();
    chk("r1_k4_dm_addr", bus[0].dm_addr, 8'h04);
    chk("r1_k4_dm_wdata", bus[0].dm_wdata, 8'h55);
    chk("r1_k4_core_reset", core_reset[0], 1);
    tick();
    chk("r1_k5_dm_we", bus[0].dm_we, 0);
    chk("r1_k5_core_reset", core_reset[0], 1);
    chk("r1_k5_busy", busy[0], 1);
    tick();
    chk("r1_k6_core_reset", core_reset[0], 1);
    tick();
    chk("r1_k7_core_reset", core_reset[0], 0);
    repeat (19) tick();
    chk("r1_k26_core_reset", core_reset[0], 0);
    chk("r1_k26_cycle_count", cycle_count[0], 19);
    tick();
    chk("r1_k27_core_reset", core_reset[0], 1);
    chk("r1_k27_dm_we", bus[0].dm_we, 0);
    chk("r1_k27_dm_addr", bus[0].dm_addr, 8'h00);
    tick();
    chk("r1_k28_dm_addr", bus[0].dm_addr, 8'h05);
    tick();
    chk("r1_pass", pass[0], 1);
    chk("r1_fail", fail[0], 0);
    chk("r1_err_count", err_count[0], 0);
    chk("r1_cycle_count", cycle_count[0], 20);
    chk("r1_busy", busy[0], 0);
    chk("r1_timed_out", timed_out[0], 0);
    chk("r1_mem1", g_m[0].mem[1], 8'h02);
    chk("r1_mem3", g_m[0].mem[3], 8'hC3);
    chk("r1_mem4", g_m[0].mem[4], 8'h55);

    // Run 2: restart from DONE, core writes 04 -> one mismatch at address 0
    core_val[0] = 8'h04;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("r2_cleared_pass", pass[0], 0);
    chk("r2_cleared_cycles", cycle_count[0], 0);
    chk("r2_busy", busy[0], 1);
    n = 0;
    while (!(pass[0] | fail[0]) && n < 60) begin tick(); n++; end
    chk("r2_finished", (n < 60), 1);
    chk("r2_fail", fail[0], 1);
    chk("r2_pass", pass[0], 0);
    chk("r2_err_count", err_count[0], 1);
    chk("r2_first_err", first_err_addr[0], 8'h00);
    chk("r2_timed_out", timed_out[0], 0);
    chk("r2_cycle_count", cycle_count[0], 20);

    // Run 3: TIMEOUT=16, no done
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    repeat (6) tick();
    chk("r3_k7_core_reset", core_reset[1], 0);
    repeat (15) tick();
    chk("r3_k22_busy", busy[1], 1);
    chk("r3_k22_cycle_count", cycle_count[1], 15);
    tick();
    chk("r3_timed_out", timed_out[1], 1);
    chk("r3_fail", fail[1], 1);
    chk("r3_pass", pass[1], 0);
    chk("r3_cycle_count", cycle_count[1], 16);
    chk("r3_busy", busy[1], 0);
    chk("r3_dm_addr", bus[1].dm_addr, 0);
    chk("r3_vec_idx", bus[1].vec_idx, 4);

    // Run 4: done coincides with the timeout cycle
    done_at[1] = 16; core_val[1] = 8'h03;
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    repeat (22) tick();
    chk("r4_k23_busy", busy[1], 1);
    chk("r4_k23_timed_out", timed_out[1], 0);
    repeat (2) tick();
    chk("r4_pass", pass[1], 1);
    chk("r4_fail", fail[1], 0);
    chk("r4_timed_out", timed_out[1], 0);
    chk("r4_cycle_count", cycle_count[1], 16);

    // Run 5: empty tables, done on first RUN cycle
    done_at[2] = 1;
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    chk("r5_k1_busy", busy[2], 1);
    chk("r5_k1_dm_we", bus[2].dm_we, 0);
    tick(); tick();
    chk("r5_k3_core_reset", core_reset[2], 0);
    tick();
    chk("r5_pass", pass[2], 1);
    chk("r5_fail", fail[2], 0);
    chk("r5_cycle_count", cycle_count[2], 1);
    chk("r5_busy", busy[2], 0);

    // Run 6: async reset in the middle of RUN
    done_at[0] = 0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (9) tick();
    chk("r6_run_core_reset", core_reset[0], 0);
    chk("r6_run_cycles", cycle_count[0], 3);
    #2 reset = 1'b1;
    #1;
    chk("r6_core_reset", core_reset[0], 1);
    chk("r6_busy", busy[0], 0);
    chk("r6_cycle_count", cycle_count[0], 0);
    chk("r6_fail", fail[0], 0);
    chk("r6_b_pass", pass[1], 0);
    chk("r6_c_pass", pass[2], 0);
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
